// File: rtl/conv_engine.sv
// conv_engine: sequential KxK convolution, one output pixel per T+2 cycles (T = cin*K*K taps); optional CONV_BIAS_EN preloads bias.
// Reads issue on the start/handshake edge, out_valid rises T+1 edges later; out_ready low stalls in OUT with no reads.
module conv_engine #(
  parameter int K          = 3,
  parameter int MAX_H      = 16,
  parameter int MAX_W      = 16,
  parameter int MAX_CIN    = 8,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int IMG_AW     = 11,
  parameter int W_AW       = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  start,
  input  logic [4:0]            cfg_in_h,
  input  logic [4:0]            cfg_in_w,
  input  logic                  cfg_stride2,
  input  logic [3:0]            cfg_cin,
  input  logic                  cfg_relu,
  output logic                  img_rd_en,
  output logic [IMG_AW-1:0]     img_addr,
  input  logic [DATA_WIDTH-1:0] img_rdata,
  output logic                  w_rd_en,
  output logic [W_AW-1:0]       w_addr,
  input  logic [DATA_WIDTH-1:0] w_rdata,
  input  logic [ACC_WIDTH-1:0]  bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_pixel,
  output logic [9:0]            out_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int PW = 2 * DATA_WIDTH + 2;
  localparam logic [4:0]    K5    = 5'(K);
  localparam logic [4:0]    MH5   = 5'(MAX_H);
  localparam logic [4:0]    MW5   = 5'(MAX_W);
  localparam logic [3:0]    MC4   = 4'(MAX_CIN);
  localparam logic [KW-1:0] KLAST = KW'(K - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;
  state_t state, state_nx;

  logic issue, load_cfg, pix_adv, done_nx, err_nx, cfg_bad;

  logic [IMG_AW-1:0] w_q, hw_q, sw_q, w_e, hw_e, sw_e;
  logic [4:0]        out_w_q, out_h_q, out_w_e, out_h_e;
  logic              s_q, s_e, relu_q;
  logic [3:0]        cin_q, cin_e;

  logic [KW-1:0]     kx_q, ky_q, cur_kx, cur_ky;
  logic [3:0]        c_q, cur_c;
  logic [W_AW-1:0]   widx_q, cur_widx;
  logic [IMG_AW-1:0] row_off_q, ch_base_q, row_org_q, col_org_q;
  logic [IMG_AW-1:0] cur_row_off, cur_ch_base, cur_row_org, cur_col_org, issue_addr;
  logic [4:0]        ox_q, oy_q, cur_ox, cur_oy;
  logic              last_kx, last_ky, last_c, last_tap, last_ox, last_oy;

  logic              rd_en_q, first_q, last_q, rd_d, first_d, last_d, pix_last_q;
  logic [9:0]        pix_idx;
  logic [IMG_AW-1:0] img_addr_q;
  logic [W_AW-1:0]   w_addr_q;
  logic [ACC_WIDTH-1:0] acc, acc_base, prod_ext, sum, out_pixel_q, bias_q;
  logic [PW-1:0]     pix_x, wgt_x, prod;
  logic [9:0]        out_idx_q;
  logic              done_q, err_q;

  assign cfg_bad = (cfg_in_h < K5) || (cfg_in_w < K5) || (cfg_in_h > MH5) ||
                   (cfg_in_w > MW5) || (cfg_cin == 4'd0) || (cfg_cin > MC4);

  // In IDLE the derived config comes straight from the inputs so tap 0 can issue on the start edge.
  always_comb begin
    if (state == IDLE) begin
      w_e     = IMG_AW'(cfg_in_w);
      hw_e    = IMG_AW'(cfg_in_h) * IMG_AW'(cfg_in_w);
      sw_e    = cfg_stride2 ? (IMG_AW'(cfg_in_w) << 1) : IMG_AW'(cfg_in_w);
      s_e     = cfg_stride2;
      cin_e   = cfg_cin;
      out_w_e = ((cfg_in_w - K5) >> cfg_stride2) + 5'd1;
      out_h_e = ((cfg_in_h - K5) >> cfg_stride2) + 5'd1;
    end else begin
      w_e     = w_q;
      hw_e    = hw_q;
      sw_e    = sw_q;
      s_e     = s_q;
      cin_e   = cin_q;
      out_w_e = out_w_q;
      out_h_e = out_h_q;
    end
  end

  always_comb begin
    if (state == IDLE) begin
      cur_kx = '0; cur_ky = '0; cur_c = '0; cur_widx = '0;
      cur_row_off = '0; cur_ch_base = '0; cur_row_org = '0; cur_col_org = '0;
      cur_ox = '0; cur_oy = '0;
    end else begin
      cur_kx = kx_q; cur_ky = ky_q; cur_c = c_q; cur_widx = widx_q;
      cur_row_off = row_off_q; cur_ch_base = ch_base_q;
      cur_row_org = row_org_q; cur_col_org = col_org_q;
      cur_ox = ox_q; cur_oy = oy_q;
    end
  end

  assign last_kx    = (cur_kx == KLAST);
  assign last_ky    = (cur_ky == KLAST);
  assign last_c     = (cur_c == cin_e - 4'd1);
  assign last_tap   = last_kx && last_ky && last_c;
  assign last_ox    = (cur_ox == out_w_e - 5'd1);
  assign last_oy    = (cur_oy == out_h_e - 5'd1);
  assign issue_addr = cur_ch_base + cur_row_off + cur_row_org + cur_col_org + IMG_AW'(cur_kx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nx;
  end

  // FETCH ends on the cycle where the last tap is on the read port.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    load_cfg = 1'b0;
    pix_adv  = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            done_nx = 1'b1;
            err_nx  = 1'b1;
          end else begin
            load_cfg = 1'b1;
            issue    = 1'b1;
            state_nx = FETCH;
          end
        end
      end
      FETCH: begin
        if (last_q) state_nx = DRAIN;
        else        issue    = 1'b1;
      end
      DRAIN: state_nx = OUT;
      OUT: begin
        if (out_ready) begin
          pix_adv = 1'b1;
          if (pix_last_q) begin
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            issue    = 1'b1;
            state_nx = FETCH;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pix_x    = {{(PW-DATA_WIDTH){1'b0}}, img_rdata};
  assign wgt_x    = {{(PW-DATA_WIDTH){w_rdata[DATA_WIDTH-1]}}, w_rdata};
  assign prod     = pix_x * wgt_x;
  assign prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
`ifdef CONV_BIAS_EN
  assign acc_base = first_d ? bias_q : acc;
`else
  logic [ACC_WIDTH-1:0] bias_unused;
  assign bias_unused = bias;
  assign acc_base    = first_d ? '0 : acc;
`endif
  assign sum = acc_base + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q <= '0; hw_q <= '0; sw_q <= '0; out_w_q <= '0; out_h_q <= '0;
      s_q <= 1'b0; relu_q <= 1'b0; cin_q <= '0;
      kx_q <= '0; ky_q <= '0; c_q <= '0; widx_q <= '0;
      row_off_q <= '0; ch_base_q <= '0; row_org_q <= '0; col_org_q <= '0;
      ox_q <= '0; oy_q <= '0; pix_last_q <= 1'b0; bias_q <= '0;
      rd_en_q <= 1'b0; first_q <= 1'b0; last_q <= 1'b0;
      rd_d <= 1'b0; first_d <= 1'b0; last_d <= 1'b0;
      img_addr_q <= '0; w_addr_q <= '0; acc <= '0; out_pixel_q <= '0;
      out_idx_q <= '0; pix_idx <= '0; done_q <= 1'b0; err_q <= 1'b0;
    end else if (clear) begin
      w_q <= '0; hw_q <= '0; sw_q <= '0; out_w_q <= '0; out_h_q <= '0;
      s_q <= 1'b0; relu_q <= 1'b0; cin_q <= '0;
      kx_q <= '0; ky_q <= '0; c_q <= '0; widx_q <= '0;
      row_off_q <= '0; ch_base_q <= '0; row_org_q <= '0; col_org_q <= '0;
      ox_q <= '0; oy_q <= '0; pix_last_q <= 1'b0; bias_q <= '0;
      rd_en_q <= 1'b0; first_q <= 1'b0; last_q <= 1'b0;
      rd_d <= 1'b0; first_d <= 1'b0; last_d <= 1'b0;
      img_addr_q <= '0; w_addr_q <= '0; acc <= '0; out_pixel_q <= '0;
      out_idx_q <= '0; pix_idx <= '0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      done_q  <= done_nx;
      err_q   <= err_nx;
      rd_en_q <= issue;
      first_q <= issue && (cur_widx == '0);
      last_q  <= issue && last_tap;
      rd_d    <= rd_en_q;
      first_d <= first_q;
      last_d  <= last_q;

      if (load_cfg) begin
        w_q <= w_e; hw_q <= hw_e; sw_q <= sw_e; s_q <= s_e; cin_q <= cin_e;
        out_w_q <= out_w_e; out_h_q <= out_h_e; relu_q <= cfg_relu;
        pix_idx <= '0;
      end else if (pix_adv) begin
        pix_idx <= pix_idx + 10'd1;
      end

      // Counters always hold the next tap to issue; they roll over to the next pixel on its last tap.
      if (issue) begin
        img_addr_q  <= issue_addr;
        w_addr_q    <= cur_widx;
        if (cur_widx == '0) bias_q <= bias;
        widx_q      <= last_tap ? '0 : cur_widx + W_AW'(1);
        kx_q        <= last_kx ? '0 : cur_kx + KW'(1);
        ky_q        <= cur_ky;
        row_off_q   <= cur_row_off;
        c_q         <= cur_c;
        ch_base_q   <= cur_ch_base;
        row_org_q   <= cur_row_org;
        col_org_q   <= cur_col_org;
        ox_q        <= cur_ox;
        oy_q        <= cur_oy;
        if (last_kx) begin
          ky_q      <= last_ky ? '0 : cur_ky + KW'(1);
          row_off_q <= last_ky ? '0 : cur_row_off + w_e;
        end
        if (last_kx && last_ky) begin
          c_q       <= last_c ? '0 : cur_c + 4'd1;
          ch_base_q <= last_c ? '0 : cur_ch_base + hw_e;
        end
        if (last_tap) begin
          pix_last_q <= last_ox && last_oy;
          if (last_ox) begin
            ox_q      <= '0;
            col_org_q <= '0;
            oy_q      <= last_oy ? '0 : cur_oy + 5'd1;
            row_org_q <= last_oy ? '0 : cur_row_org + sw_e;
          end else begin
            ox_q      <= cur_ox + 5'd1;
            col_org_q <= cur_col_org + (s_e ? IMG_AW'(2) : IMG_AW'(1));
          end
        end
      end

      if (rd_d) begin
        acc <= sum;
        if (last_d) begin
          out_pixel_q <= (relu_q && sum[ACC_WIDTH-1]) ? '0 : sum;
          out_idx_q   <= pix_idx;
        end
      end
    end
  end

  assign img_rd_en = rd_en_q;
  assign w_rd_en   = rd_en_q;
  assign img_addr  = img_addr_q;
  assign w_addr    = w_addr_q;
  assign out_valid = (state == OUT);
  assign out_pixel = out_pixel_q;
  assign out_idx   = out_idx_q;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_conv_engine.sv
// Directed bench for conv_engine: scoreboard queue filled by stimulus, drained by an output monitor.
module tb_conv_engine;

  logic        clk = 1'b0;
  logic        rst_n, clear, start;
  logic [4:0]  cfg_in_h, cfg_in_w;
  logic        cfg_stride2, cfg_relu;
  logic [3:0]  cfg_cin;
  logic        img_rd_en, w_rd_en;
  logic [10:0] img_addr;
  logic [6:0]  w_addr;
  logic [7:0]  img_rdata, w_rdata;
  logic [23:0] bias;
  logic        out_valid, out_ready;
  logic [23:0] out_pixel;
  logic [9:0]  out_idx;
  logic        busy, done, cfg_err;

  conv_engine dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
    .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w), .cfg_stride2(cfg_stride2),
    .cfg_cin(cfg_cin), .cfg_relu(cfg_relu),
    .img_rd_en(img_rd_en), .img_addr(img_addr), .img_rdata(img_rdata),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rdata(w_rdata), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_idx(out_idx), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  logic [7:0] img_mem [0:2047];
  logic [7:0] w_mem   [0:127];

  always @(posedge clk) begin
    if (img_rd_en) img_rdata <= img_mem[img_addr];
    if (w_rd_en)   w_rdata   <= w_mem[w_addr];
  end

  typedef struct packed {
    logic [23:0] pix;
    logic [9:0]  idx;
  } exp_t;
  exp_t exp_q[$];
  logic [10:0] first_addrs[$];

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int rd_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] p, input logic [9:0] i);
    exp_t e;
    e.pix = p;
    e.idx = i;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [4:0] h, input logic [4:0] w, input logic s2,
                             input logic [3:0] cin, input logic relu);
    cfg_in_h = h; cfg_in_w = w; cfg_stride2 = s2; cfg_cin = cin; cfg_relu = relu;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n;
    n = 0;
    while (n < maxc && done !== 1'b1) begin
      tick();
      n++;
    end
    check(name, done, 1);
  endtask

  task automatic load_raster5();
    for (int i = 0; i < 25; i++) img_mem[i] = 8'(i);
    for (int i = 0; i < 9; i++) w_mem[i] = (i == 4) ? 8'd1 : 8'd0;
  endtask

  // Scoreboard monitor: one pop per accepted output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got out_idx %0d want no output", out_idx);
        end else begin
          e = exp_q.pop_front();
          check("sb_pixel", out_pixel, e.pix);
          check("sb_idx", out_idx, e.idx);
        end
      end
    end
  end

  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (img_rd_en === 1'b1) rd_cnt++;
      if (img_rd_en !== w_rd_en) rd_mis++;
      if (img_rd_en === 1'b1 && !prev) first_addrs.push_back(img_addr);
      prev = img_rd_en;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, rd0, fb, unstable;
    logic [23:0] p0;
    logic [9:0]  i0;

    for (int i = 0; i < 2048; i++) img_mem[i] = 8'd0;
    for (int i = 0; i < 128; i++) w_mem[i] = 8'd0;
    rst_n = 1'b0; clear = 1'b0; start = 1'b0; out_ready = 1'b1; bias = 24'd0;
    cfg_in_h = 5'd0; cfg_in_w = 5'd0; cfg_stride2 = 1'b0; cfg_cin = 4'd0; cfg_relu = 1'b0;
    #22;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rd_en", img_rd_en, 0);
    check("rst_done", done, 0);
    check("rst_pixel", out_pixel, 0);
    check("rst_addr", img_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single 3x3 pixel, all ones times weight 2.
    for (int i = 0; i < 9; i++) begin img_mem[i] = 8'd1; w_mem[i] = 8'd2; end
    push(24'd18, 10'd0);
    rd0 = rd_cnt;
    start_layer(5'd3, 5'd3, 1'b0, 4'd1, 1'b1);
    n = 0;
    while (n < 40 && out_valid !== 1'b1) begin tick(); n++; end
    check("latency", n, 10);
    tick();
    check("done_on_handshake", done, 1);
    check("idle_after_last", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    check("rd_cycles_t9", rd_cnt - rd0, 9);

    // 5x5 raster, centre tap, stride 1.
    load_raster5();
    for (int i = 0; i < 9; i++) push(24'(6 + (i / 3) * 5 + (i % 3)), 10'(i));
    rd0 = rd_cnt;
    fb = first_addrs.size();
    start_layer(5'd5, 5'd5, 1'b0, 4'd1, 1'b0);
    wait_done("done_s1", 500);
    check("rd_cycles_s1", rd_cnt - rd0, 81);
    check("first_addr_s1_px1", first_addrs[fb + 1], 1);
    check("sb_drained_s1", exp_q.size(), 0);

    // Stride 2.
    push(24'd6, 10'd0); push(24'd8, 10'd1); push(24'd16, 10'd2); push(24'd18, 10'd3);
    fb = first_addrs.size();
    start_layer(5'd5, 5'd5, 1'b1, 4'd1, 1'b0);
    wait_done("done_s2", 300);
    check("first_addr_s2_px1", first_addrs[fb + 1], 2);
    check("first_addr_s2_px2", first_addrs[fb + 2], 10);
    check("sb_drained_s2", exp_q.size(), 0);

    // Two channels with negative weights.
    for (int i = 0; i < 9; i++) begin
      img_mem[i] = 8'd10; img_mem[9 + i] = 8'd1;
      w_mem[i] = 8'hFF;   w_mem[9 + i] = 8'd1;
    end
    bias = 24'd100;
`ifdef CONV_BIAS_EN
    push(24'd19, 10'd0);
`else
    push(-24'sd81, 10'd0);
`endif
    rd0 = rd_cnt;
    start_layer(5'd3, 5'd3, 1'b0, 4'd2, 1'b0);
    wait_done("done_cin2", 100);
    check("rd_cycles_cin2", rd_cnt - rd0, 18);
`ifdef CONV_BIAS_EN
    push(24'd19, 10'd0);
`else
    push(24'd0, 10'd0);
`endif
    start_layer(5'd3, 5'd3, 1'b0, 4'd2, 1'b1);
    wait_done("done_cin2_relu", 100);
    check("sb_drained_cin2", exp_q.size(), 0);
    bias = 24'd0;

    // Back-pressure on first pixel.
    load_raster5();
    for (int i = 0; i < 9; i++) push(24'(6 + (i / 3) * 5 + (i % 3)), 10'(i));
    out_ready = 1'b0;
    start_layer(5'd5, 5'd5, 1'b0, 4'd1, 1'b0);
    n = 0;
    while (n < 40 && out_valid !== 1'b1) begin tick(); n++; end
    check("bp_valid_seen", out_valid, 1);
    p0 = out_pixel; i0 = out_idx; rd0 = rd_cnt; unstable = 0;
    repeat (20) begin
      tick();
      if (out_pixel !== p0 || out_idx !== i0 || out_valid !== 1'b1) unstable++;
    end
    check("bp_stable", unstable, 0);
    check("bp_no_reads", rd_cnt - rd0, 0);
    out_ready = 1'b1;
    wait_done("done_bp", 500);
    check("sb_drained_bp", exp_q.size(), 0);

    // Clear during FETCH.
    start_layer(5'd5, 5'd5, 1'b0, 4'd1, 1'b0);
    repeat (3) tick();
    check("clr_pre_rd", img_rd_en, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy", busy, 0);
    check("clr_valid", out_valid, 0);
    check("clr_rd_en", img_rd_en, 0);
    check("clr_w_rd_en", w_rd_en, 0);
    check("clr_pixel", out_pixel, 0);
    rd0 = rd_cnt;
    repeat (5) tick();
    check("clr_no_reads", rd_cnt - rd0, 0);

    // Illegal configs.
    rd0 = rd_cnt;
    start_layer(5'd3, 5'd2, 1'b0, 4'd1, 1'b0);
    check("bad_w_done", done, 1);
    check("bad_w_err", cfg_err, 1);
    check("bad_w_busy", busy, 0);
    tick();
    check("bad_w_err_pulse", cfg_err, 0);
    start_layer(5'd3, 5'd3, 1'b0, 4'd0, 1'b0);
    check("bad_cin_err", cfg_err, 1);
    start_layer(5'd17, 5'd3, 1'b0, 4'd1, 1'b0);
    check("bad_h_err", cfg_err, 1);
    repeat (3) tick();
    check("bad_no_reads", rd_cnt - rd0, 0);

    // Asynchronous reset during the third pixel's fetch.
    push(24'd6, 10'd0); push(24'd7, 10'd1);
    start_layer(5'd5, 5'd5, 1'b0, 4'd1, 1'b0);
    repeat (25) tick();
    check("ar_pre_rd", img_rd_en, 1);
    check("ar_pre_idx", out_idx, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rd_en", img_rd_en, 0);
    check("ar_busy", busy, 0);
    check("ar_valid", out_valid, 0);
    check("ar_pixel", out_pixel, 0);
    check("ar_idx", out_idx, 0);
    check("ar_addr", img_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("sb_drained_final", exp_q.size(), 0);
    check("rd_strobe_match", rd_mis, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
